sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM controller command/data port between two requesters: the GBA cartridge bus engine (real-time, high priority) and the USB transfer engine (bulk, low priority).
- Each requester side uses the mux_usb-style protocol: request held until acknowledged; reads complete when rd_valid returns.
- Sits between both engines and the SDRAM controller.
- Provides fixed priority with USB anti-starvation, a registered command slot, and in-order read-data routing.

---
 rtl/sdram_port_arbiter_if.sv | 53 +++++
 rtl/sdram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and SDRAM-controller-side bundles for the SDRAM port arbiter.
// Requesters hold rd or wr until they are acknowledged. A write is acknowledged by wr_ready.
// A read is acknowledged by the rd_valid pulse.

interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 32
);
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    // The requester engine drives the request fields.
    modport master (
        output rd, wr, addr, wr_data,
        input  wr_ready, rd_valid, rd_data
    );

    // The arbiter answers the requester.
    modport slave (
        input  rd, wr, addr, wr_data,
        output wr_ready, rd_valid, rd_data
    );
endinterface

interface sdram_mem_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    // The arbiter issues commands.
    modport master (
        output cmd_valid, cmd_we, addr, wdata,
        input  cmd_ready, rd_valid, rd_data
    );

    // The SDRAM controller accepts commands and returns read data in order.
    modport slave (
        input  cmd_valid, cmd_we, addr, wdata,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between the GBA cartridge engine and the USB engine.
// GBA has fixed priority. USB is forced through after USB_STARVE_MAX consecutive GBA grants.
// Commands leave from a single registered slot.
// Read data is routed back to its requester through a small owner FIFO, which keeps issue order.

module sdram_port_arbiter #(
    parameter int ADDR_W         = 29,
    parameter int DATA_W         = 32,
    parameter int USB_STARVE_MAX = 64
) (
    input  logic                clk,
    input  logic                rst,
    sdram_port_arbiter_if.slave gba,
    sdram_port_arbiter_if.slave usb,
    sdram_mem_if.master         mem,
    output logic                err_orphan_rd
);
    localparam int CNT_W = $clog2(USB_STARVE_MAX + 1);

    logic              gba_elig;
    logic              usb_elig;
    logic              load_en;
    logic              grant_gba;
    logic              grant_usb;
    logic              starve_hit;
    logic              push;
    logic              pop;

    logic [CNT_W-1:0]  starve_cnt;
    logic              pend_gba;
    logic              pend_usb;

    logic              slot_vld;
    logic              slot_we;
    logic              slot_owner;          // 1 = USB, 0 = GBA
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_wdata;

    logic [1:0]        fifo_q;              // owner bits; entry 0 is the oldest
    logic [1:0]        fifo_cnt;

    logic              gba_rd_vld_p1;
    logic              usb_rd_vld_p1;
    logic [DATA_W-1:0] gba_rd_data_p1;
    logic [DATA_W-1:0] usb_rd_data_p1;

    // Eligibility, grant selection, write acks and owner-FIFO push/pop strobes.
    always_comb begin
        gba_elig     = (gba.rd | gba.wr) & ~pend_gba;
        usb_elig     = (usb.rd | usb.wr) & ~pend_usb;
        starve_hit   = (starve_cnt == CNT_W'(USB_STARVE_MAX));
        load_en      = ~slot_vld | mem.cmd_ready;
        grant_usb    = load_en & usb_elig & (~gba_elig | starve_hit);
        grant_gba    = load_en & gba_elig & ~grant_usb;
        gba.wr_ready = grant_gba & gba.wr;
        usb.wr_ready = grant_usb & usb.wr;
        push         = slot_vld & mem.cmd_ready & ~slot_we;
        pop          = mem.rd_valid & (fifo_cnt != 2'd0);
    end

    // Count consecutive GBA wins while USB waits. The count saturates at the forcing threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!usb_elig || grant_usb) begin
            starve_cnt <= '0;
        end else if (grant_gba && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Command slot: load the winner whenever the slot is empty or just accepted.
    // Otherwise hold the command stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld   <= 1'b0;
            slot_we    <= 1'b0;
            slot_owner <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
        end else if (load_en) begin
            slot_vld <= grant_gba | grant_usb;
            if (grant_usb) begin
                slot_we    <= usb.wr;
                slot_owner <= 1'b1;
                slot_addr  <= usb.addr;
                slot_wdata <= usb.wr_data;
            end else if (grant_gba) begin
                slot_we    <= gba.wr;
                slot_owner <= 1'b0;
                slot_addr  <= gba.addr;
                slot_wdata <= gba.wr_data;
            end
        end
    end

    assign mem.cmd_valid = slot_vld;
    assign mem.cmd_we    = slot_we;
    assign mem.addr      = slot_addr;
    assign mem.wdata     = slot_wdata;

    // Pending-read flags block re-arbitration until the data pulse has been delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_gba <= 1'b0;
            pend_usb <= 1'b0;
        end else begin
            pend_gba <= (pend_gba & ~gba_rd_vld_p1) | (grant_gba & ~gba.wr);
            pend_usb <= (pend_usb & ~usb_rd_vld_p1) | (grant_usb & ~usb.wr);
        end
    end

    // Owner FIFO (depth 2): push when a read command is accepted, pop on each return.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q   <= 2'b00;
            fifo_cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    fifo_q[fifo_cnt[0]] <= slot_owner;
                    fifo_cnt            <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_q[0] <= fifo_q[1];
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_q[0] <= slot_owner;
                    end else begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= slot_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    // Return stage: register the data to the owner and pulse its valid one cycle later.
    // A return with nothing outstanding is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            gba_rd_vld_p1  <= 1'b0;
            usb_rd_vld_p1  <= 1'b0;
            gba_rd_data_p1 <= '0;
            usb_rd_data_p1 <= '0;
            err_orphan_rd  <= 1'b0;
        end else begin
            gba_rd_vld_p1 <= pop & ~fifo_q[0];
            usb_rd_vld_p1 <= pop & fifo_q[0];
            if (pop && !fifo_q[0]) begin
                gba_rd_data_p1 <= mem.rd_data;
            end
            if (pop && fifo_q[0]) begin
                usb_rd_data_p1 <= mem.rd_data;
            end
            if (mem.rd_valid && fifo_cnt == 2'd0) begin
                err_orphan_rd <= 1'b1;
            end
        end
    end

    assign gba.rd_valid = gba_rd_vld_p1;
    assign gba.rd_data  = gba_rd_data_p1;
    assign usb.rd_valid = usb_rd_vld_p1;
    assign usb.rd_data  = usb_rd_data_p1;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter.
// Stimulus pushes the expected commands and read data into queues.
// A monitor on the falling edge pops those queues and compares them with what the DUT presents.
// The memory responder returns addr ^ 0xC0DE0000 for each read, LAT cycles after the command.

module tb_sdram_port_arbiter;
    localparam int ADDR_W = 29;
    localparam int DATA_W = 32;
    localparam int STARVE = 4;
    localparam int LAT    = 5;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_orphan_rd;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) gba_if ();
    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) usb_if ();
    sdram_mem_if          #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .USB_STARVE_MAX(STARVE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gba(gba_if),
        .usb(usb_if),
        .mem(mem_if),
        .err_orphan_rd(err_orphan_rd)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int n_cmds = 0;
    int cyc    = 0;

    cmd_t              exp_cmd[$];
    logic [DATA_W-1:0] exp_gba[$];
    logic [DATA_W-1:0] exp_usb[$];
    int                resp_due[$];
    logic [DATA_W-1:0] resp_data[$];

    logic orphan_req = 1'b0;
    logic prev_mrv   = 1'b0;
    cmd_t mon_e;
    cmd_t mon_a;
    logic [DATA_W-1:0] mon_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {3'b000, a} ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: returns reads in order, or injects one orphan return on request.
    always @(posedge clk) begin
        #1;
        mem_if.rd_valid = 1'b0;
        if (orphan_req) begin
            mem_if.rd_valid = 1'b1;
            mem_if.rd_data  = 32'hBAD0_BAD0;
            orphan_req      = 1'b0;
        end else if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
            void'(resp_due.pop_front());
            mem_if.rd_valid = 1'b1;
            mem_if.rd_data  = resp_data.pop_front();
        end
    end

    // Monitor: compare every accepted command and every read-data pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_if.cmd_valid && mem_if.cmd_ready) begin
                n_cmds++;
                mon_a = '{we: mem_if.cmd_we, addr: mem_if.addr,
                          wdata: mem_if.cmd_we ? mem_if.wdata : '0};
                if (exp_cmd.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got we=%0d addr=0x%0h, expected no command",
                             mon_a.we, mon_a.addr);
                end else begin
                    mon_e = exp_cmd.pop_front();
                    chk("cmd", 64'(mon_a), 64'(mon_e));
                end
                if (!mem_if.cmd_we) begin
                    resp_due.push_back(cyc + LAT);
                    resp_data.push_back(mem_fn(mem_if.addr));
                end
            end
            if (gba_if.rd_valid) begin
                if (exp_gba.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL gba_rd_unexpected: got data 0x%0h, expected no return", gba_if.rd_data);
                end else begin
                    mon_d = exp_gba.pop_front();
                    chk("gba_rd_data", 64'(gba_if.rd_data), 64'(mon_d));
                    chk("gba_rd_latency", 64'(prev_mrv), 64'(1));
                end
            end
            if (usb_if.rd_valid) begin
                if (exp_usb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL usb_rd_unexpected: got data 0x%0h, expected no return", usb_if.rd_data);
                end else begin
                    mon_d = exp_usb.pop_front();
                    chk("usb_rd_data", 64'(usb_if.rd_data), 64'(mon_d));
                    chk("usb_rd_latency", 64'(prev_mrv), 64'(1));
                end
            end
        end
        prev_mrv = mem_if.rd_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    logic g, u, gv, uv, gdone, udone, got;
    int   gcnt, ucnt, base;

    initial begin
        gba_if.rd = 0; gba_if.wr = 0; gba_if.addr = '0; gba_if.wr_data = '0;
        usb_if.rd = 0; usb_if.wr = 0; usb_if.addr = '0; usb_if.wr_data = '0;
        mem_if.cmd_ready = 0; mem_if.rd_valid = 0; mem_if.rd_data = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", 64'({mem_if.cmd_valid, mem_if.cmd_we, mem_if.addr}), 64'(0));
        chk("rst_wdata", 64'(mem_if.wdata), 64'(0));
        chk("rst_gba", 64'({gba_if.wr_ready, gba_if.rd_valid, gba_if.rd_data}), 64'(0));
        chk("rst_usb", 64'({usb_if.wr_ready, usb_if.rd_valid, usb_if.rd_data}), 64'(0));
        chk("rst_err", 64'(err_orphan_rd), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mem_if.cmd_ready = 1'b1;

        // Single GBA write: ack in cycle 0, command visible in cycle 1
        exp_cmd.push_back('{we: 1'b1, addr: 29'h100, wdata: 32'hDEAD_BEEF});
        gba_if.wr = 1; gba_if.addr = 29'h100; gba_if.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_wr_ready_c0", 64'(gba_if.wr_ready), 64'(1));
        chk("t1_cmd_valid_c0", 64'(mem_if.cmd_valid), 64'(0));
        @(posedge clk); #1;
        gba_if.wr = 0;
        @(negedge clk);
        chk("t1_cmd_c1", 64'({mem_if.cmd_valid, mem_if.cmd_we, mem_if.addr}), 64'({2'b11, 29'h100}));
        chk("t1_wr_ready_c1", 64'(gba_if.wr_ready), 64'(0));

        // GBA read of 0x200, held until data returns: exactly one command
        @(posedge clk); #1;
        base = n_cmds;
        exp_cmd.push_back('{we: 1'b0, addr: 29'h200, wdata: '0});
        exp_gba.push_back(32'hC0DE_0200);
        gba_if.rd = 1; gba_if.addr = 29'h200;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (gba_if.rd_valid) got = 1;
        end
        chk("t2_gba_rd_returned", 64'(got), 64'(1));
        @(posedge clk); #1;
        gba_if.rd = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_one_cmd", 64'(n_cmds - base), 64'(1));

        // Both write continuously: GGGGUGGGGU with the starvation threshold at 4
        gcnt = 0; ucnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                exp_cmd.push_back('{we: 1'b1, addr: 29'h2000 + 29'(4 * ucnt), wdata: 32'h7000_0000 + 32'(ucnt)});
                ucnt++;
            end else begin
                exp_cmd.push_back('{we: 1'b1, addr: 29'h1000 + 29'(4 * gcnt), wdata: 32'h6000_0000 + 32'(gcnt)});
                gcnt++;
            end
        end
        gcnt = 0; ucnt = 0;
        gba_if.wr = 1; gba_if.addr = 29'h1000; gba_if.wr_data = 32'h6000_0000;
        usb_if.wr = 1; usb_if.addr = 29'h2000; usb_if.wr_data = 32'h7000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g = gba_if.wr_ready;
            u = usb_if.wr_ready;
            chk("t3_grant", 64'({g, u}), (i == 4 || i == 9) ? 64'(2'b01) : 64'(2'b10));
            @(posedge clk); #1;
            if (g) begin
                gcnt++;
                gba_if.addr = 29'h1000 + 29'(4 * gcnt); gba_if.wr_data = 32'h6000_0000 + 32'(gcnt);
            end
            if (u) begin
                ucnt++;
                usb_if.addr = 29'h2000 + 29'(4 * ucnt); usb_if.wr_data = 32'h7000_0000 + 32'(ucnt);
            end
        end
        gba_if.wr = 0; usb_if.wr = 0;
        repeat (3) @(posedge clk);
        #1;

        // GBA read and USB read back-to-back, in-order returns routed to their owners
        exp_cmd.push_back('{we: 1'b0, addr: 29'h300, wdata: '0});
        exp_cmd.push_back('{we: 1'b0, addr: 29'h400, wdata: '0});
        exp_gba.push_back(32'hC0DE_0300);
        exp_usb.push_back(32'hC0DE_0400);
        gba_if.rd = 1; gba_if.addr = 29'h300;
        usb_if.rd = 1; usb_if.addr = 29'h400;
        gdone = 0; udone = 0;
        for (int i = 0; i < 40 && !(gdone && udone); i++) begin
            @(negedge clk);
            gv = gba_if.rd_valid;
            uv = usb_if.rd_valid;
            @(posedge clk); #1;
            if (gv) begin gba_if.rd = 0; gdone = 1; end
            if (uv) begin usb_if.rd = 0; udone = 1; end
        end
        chk("t4_both_returned", 64'({gdone, udone}), 64'(2'b11));
        gba_if.rd = 0; usb_if.rd = 0;
        repeat (2) @(posedge clk);
        #1;

        // Controller stalls with the slot full: slot stable, no acks, resume when ready rises
        mem_if.cmd_ready = 0;
        exp_cmd.push_back('{we: 1'b1, addr: 29'h500, wdata: 32'h1111_1111});
        exp_cmd.push_back('{we: 1'b1, addr: 29'h600, wdata: 32'h2222_2222});
        gba_if.wr = 1; gba_if.addr = 29'h500; gba_if.wr_data = 32'h1111_1111;
        @(negedge clk);
        chk("t5_gba_wr_ready", 64'(gba_if.wr_ready), 64'(1));
        @(posedge clk); #1;
        gba_if.wr = 0;
        usb_if.wr = 1; usb_if.addr = 29'h600; usb_if.wr_data = 32'h2222_2222;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_slot_stable", 64'({mem_if.cmd_valid, mem_if.cmd_we, mem_if.addr, mem_if.wdata}),
                64'({2'b11, 29'h500, 32'h1111_1111}));
            chk("t5_no_wr_ready", 64'({gba_if.wr_ready, usb_if.wr_ready}), 64'(0));
        end
        @(posedge clk); #1;
        mem_if.cmd_ready = 1;
        @(negedge clk);
        chk("t5_resume", 64'(usb_if.wr_ready), 64'(1));
        @(posedge clk); #1;
        usb_if.wr = 0;
        @(negedge clk);
        chk("t5_usb_slot", 64'({mem_if.cmd_valid, mem_if.addr}), 64'({1'b1, 29'h600}));
        repeat (3) @(posedge clk);
        #1;

        // Orphan return: no data pulse, sticky error until reset
        chk("t6_idle_queues", 64'(exp_cmd.size() + exp_gba.size() + exp_usb.size() + resp_due.size()), 64'(0));
        chk("t6_err_before", 64'(err_orphan_rd), 64'(0));
        @(negedge clk);
        orphan_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_err_set", 64'(err_orphan_rd), 64'(1));
        repeat (4) @(negedge clk);
        chk("t6_err_sticky", 64'(err_orphan_rd), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_err_cleared", 64'(err_orphan_rd), 64'(0));

        // Reset while a read is outstanding: the late return is treated as an orphan
        @(posedge clk); #1;
        exp_cmd.push_back('{we: 1'b0, addr: 29'h700, wdata: '0});
        gba_if.rd = 1; gba_if.addr = 29'h700;
        @(negedge clk);
        @(negedge clk);
        chk("t7_cmd_issued", 64'({mem_if.cmd_valid, mem_if.addr}), 64'({1'b1, 29'h700}));
        @(posedge clk); #1;
        rst = 1'b1;
        gba_if.rd = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("t7_orphan_after_reset", 64'(err_orphan_rd), 64'(1));

        chk("end_queues_empty", 64'(exp_cmd.size() + exp_gba.size() + exp_usb.size() + resp_due.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
